clkdiv_monitor: RTL and testbench
=================================

CLKDIV_MONITOR -- requirements
Module: clkdiv_monitor

Interface
REQ-001 Parameter DIV, default 7: expected divider ratio, in clk_in cycles per div_clk period.
REQ-002 Parameter LOCK_PERIODS, default 4: consecutive good periods required to assert locked.
REQ-003 Parameter CW, default 8: width of the measurement counters.
REQ-004 Port clk_in, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-006 Port div_clk, input, 1 bit: divided clock from the divide-by-DIV stage, sampled as data on clk_in.
REQ-007 Port enable, input, 1 bit: 1 = monitor runs; 0 = monitor held in IDLE.
REQ-008 Port clear_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-009 Port locked, output, 1 bit: DIV-ratio lock achieved.
REQ-010 Port err_period, output, 1 bit: sticky flag; a measured period was not equal to DIV.
REQ-011 Port err_duty, output, 1 bit: sticky flag; a measured high time was outside the legal window.
REQ-012 Port err_timeout, output, 1 bit: sticky flag; no div_clk rise was seen within the timeout window.
REQ-013 Port period_q, output, CW bits: last measured period, in clk_in cycles.
REQ-014 Port high_q, output, CW bits: last measured high time, in clk_in cycles.
REQ-015 Port rise_count, output, 16 bits: count of div_clk rises while not in IDLE.

Function
REQ-016 div_clk is registered each cycle into d_q.
REQ-017 rise is true in a cycle when div_clk = 1 and d_q = 0.
REQ-018 The FSM has the states IDLE, ACQUIRE, MEASURE and LOCKED.
REQ-019 IDLE: when enable = 1, go to ACQUIRE.
REQ-020 Any state: when enable = 0, go to IDLE next cycle; counters and the good-period count clear; sticky flags, period_q and high_q hold.
REQ-021 ACQUIRE: on rise, go to MEASURE; set run_cnt = 1; set hi_cnt = 1; set good = 0; no measurement is captured.
REQ-022 Counters in MEASURE/LOCKED, non-rise cycle: run_cnt increments; hi_cnt increments when div_clk = 1; both saturate at 2^CW-1.
REQ-023 Counters in MEASURE/LOCKED, rise cycle: period_q <= run_cnt; high_q <= hi_cnt; then run_cnt <= 1 and hi_cnt <= 1.
REQ-024 A period is good when run_cnt = DIV and hi_cnt is within [DIV/2, DIV/2+1], using integer division (3..4 for DIV = 7).
REQ-025 On a rise with run_cnt != DIV, set err_period.
REQ-026 On a rise with hi_cnt outside the window of REQ-024, set err_duty.
REQ-027 MEASURE, rise: a good period increments good; when good reaches LOCK_PERIODS, go to LOCKED.
REQ-028 MEASURE, rise: a bad period sets good = 0 and stays in MEASURE.
REQ-029 LOCKED, rise: a bad period goes to MEASURE with good = 0; locked deasserts the cycle after that rise.
REQ-030 Timeout: in MEASURE or LOCKED, when run_cnt reaches 2*DIV with no rise, set err_timeout and go to ACQUIRE.
REQ-031 locked = 1 exactly while in LOCKED, driven from a register.
REQ-032 rise_count increments on every rise outside IDLE and wraps from 0xFFFF to 0.
REQ-033 Sticky flags clear on clear_err = 1, except a new error detected in the same cycle: the set wins.
REQ-034 A sticky flag stays set until clear_err or rst.
REQ-035 A simultaneous rise and the timeout threshold is impossible by construction; the rise takes precedence.

Reset
REQ-036 rst = 1 sets state = IDLE and clears d_q, run_cnt, hi_cnt, good, period_q, high_q, rise_count, locked and all error flags to 0.
REQ-037 rst overrides enable and clear_err.
REQ-038 rst asserted mid-operation clears lock within one cycle.

Verification
REQ-039 Nominal: DIV = 7, div_clk with 7-cycle period and high 4 cycles, enable = 1 -> period_q = 7 and high_q = 4; locked = 1 after the 5th rise (1 acquire + 4 good); no error flags set.
REQ-040 Duty window: high time 3 -> no error; high time 2 -> err_duty = 1, locked drops, relock after 4 further good periods.
REQ-041 Bad period: one 8-cycle period while LOCKED -> err_period = 1, period_q = 8, locked = 0 the next cycle.
REQ-042 Stuck clock: div_clk held at 0 while LOCKED -> err_timeout = 1 and state ACQUIRE 14 cycles after the last rise; locked = 0.
REQ-043 Clear priority: clear_err = 1 in the same cycle as a new period error -> err_period remains 1; clear_err alone on a later cycle -> err_period = 0.
REQ-044 Reset mid-lock: rst pulsed for 1 cycle while LOCKED -> all outputs 0 the next cycle; rise_count restarts at 0.

Source files
------------

// File: rtl/clkdiv_monitor.sv
// clkdiv_monitor: checks a divided clock (sampled as data on clk_in) for the
// expected period and duty cycle, reports lock and keeps sticky error flags.
module clkdiv_monitor #(
    parameter int unsigned DIV          = 7,
    parameter int unsigned LOCK_PERIODS = 4,
    parameter int unsigned CW           = 8
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          div_clk,
    input  logic          enable,
    input  logic          clear_err,
    output logic          locked,
    output logic          err_period,
    output logic          err_duty,
    output logic          err_timeout,
    output logic [CW-1:0] period_q,
    output logic [CW-1:0] high_q,
    output logic [15:0]   rise_count
);

    localparam int unsigned GW = $clog2(LOCK_PERIODS + 1);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] DIV_C   = CW'(DIV);
    localparam logic [CW-1:0] TO_C    = CW'(2 * DIV);
    localparam logic [CW-1:0] HI_LO   = CW'(DIV / 2);
    localparam logic [CW-1:0] HI_HI   = CW'(DIV / 2 + 1);
    localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_PERIODS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            d_q;
    logic [CW-1:0]   run_cnt_q, run_cnt_d;
    logic [CW-1:0]   hi_cnt_q, hi_cnt_d;
    logic [GW-1:0]   good_q, good_d;
    logic [GW-1:0]   good_inc;
    logic [CW-1:0]   period_d, high_d;
    logic [15:0]     rise_count_d;
    logic            locked_d;
    logic            err_period_d, err_duty_d, err_timeout_d;
    logic            rise;
    logic            per_bad, duty_bad;

    // Edge detect and period classification from the current counters
    assign rise     = div_clk & ~d_q;
    assign per_bad  = (run_cnt_q != DIV_C);
    assign duty_bad = (hi_cnt_q < HI_LO) || (hi_cnt_q > HI_HI);
    assign good_inc = good_q + GW'(1);

    // Next-state, counter and flag logic
    always_comb begin
        state_d       = state_q;
        run_cnt_d     = run_cnt_q;
        hi_cnt_d      = hi_cnt_q;
        good_d        = good_q;
        period_d      = period_q;
        high_d        = high_q;
        rise_count_d  = rise_count;
        err_period_d  = err_period  & ~clear_err;
        err_duty_d    = err_duty    & ~clear_err;
        err_timeout_d = err_timeout & ~clear_err;

        if (!enable) begin
            state_d   = IDLE;
            run_cnt_d = '0;
            hi_cnt_d  = '0;
            good_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (rise) begin
                        state_d      = MEASURE;
                        run_cnt_d    = CW'(1);
                        hi_cnt_d     = CW'(1);
                        good_d       = '0;
                        rise_count_d = rise_count + 16'd1;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        // Rise closes a period: capture it, restart counters, grade it
                        rise_count_d = rise_count + 16'd1;
                        period_d     = run_cnt_q;
                        high_d       = hi_cnt_q;
                        run_cnt_d    = CW'(1);
                        hi_cnt_d     = CW'(1);
                        if (per_bad)  err_period_d = 1'b1;
                        if (duty_bad) err_duty_d   = 1'b1;
                        if (per_bad || duty_bad) begin
                            good_d  = '0;
                            state_d = MEASURE;
                        end else if (state_q == MEASURE) begin
                            good_d = good_inc;
                            if (good_inc >= LOCK_C) state_d = LOCKED;
                        end
                    end else if (run_cnt_q >= TO_C) begin
                        // No rise within two nominal periods: reacquire
                        err_timeout_d = 1'b1;
                        state_d       = ACQUIRE;
                    end else begin
                        if (run_cnt_q != CNT_MAX) run_cnt_d = run_cnt_q + CW'(1);
                        if (div_clk && (hi_cnt_q != CNT_MAX)) hi_cnt_d = hi_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= 1'b0;
            run_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            good_q      <= '0;
            period_q    <= '0;
            high_q      <= '0;
            rise_count  <= '0;
            locked      <= 1'b0;
            err_period  <= 1'b0;
            err_duty    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= div_clk;
            run_cnt_q   <= run_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            good_q      <= good_d;
            period_q    <= period_d;
            high_q      <= high_d;
            rise_count  <= rise_count_d;
            locked      <= locked_d;
            err_period  <= err_period_d;
            err_duty    <= err_duty_d;
            err_timeout <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Scoreboard bench for clkdiv_monitor with DIV=7, LOCK_PERIODS=4, CW=8.
module tb_clkdiv_monitor;

    logic        clk_in;
    logic        rst;
    logic        div_clk;
    logic        enable;
    logic        clear_err;
    logic        locked;
    logic        err_period;
    logic        err_duty;
    logic        err_timeout;
    logic [7:0]  period_q;
    logic [7:0]  high_q;
    logic [15:0] rise_count;

    clkdiv_monitor #(
        .DIV          (7),
        .LOCK_PERIODS (4),
        .CW           (8)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .div_clk     (div_clk),
        .enable      (enable),
        .clear_err   (clear_err),
        .locked      (locked),
        .err_period  (err_period),
        .err_duty    (err_duty),
        .err_timeout (err_timeout),
        .period_q    (period_q),
        .high_q      (high_q),
        .rise_count  (rise_count)
    );

    // Expected outcome of one div_clk rise, as seen one edge later
    typedef struct {
        bit       meas;
        int       period;
        int       high;
        bit       lk;
        bit [2:0] errs;   // {err_period, err_duty, err_timeout}
        int       rc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   rc_exp   = 0;
    int   prev_len = 0;
    int   prev_hi  = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One div_clk period of len cycles, high for hi cycles, starting with a rise.
    // The pushed entry describes what the rise reports about the previous period.
    task automatic pulse(input int len, input int hi, input bit clr, input bit meas,
                         input bit lk, input bit [2:0] errs);
        exp_t e;
        @(negedge clk_in);
        div_clk   = 1'b1;
        clear_err = clr;
        rc_exp    = (rc_exp + 1) & 32'hFFFF;
        e.meas    = meas;
        e.period  = prev_len;
        e.high    = prev_hi;
        e.lk      = lk;
        e.errs    = errs;
        e.rc      = rc_exp;
        sb.push_back(e);
        prev_len  = len;
        prev_hi   = hi;
        for (int i = 1; i < len; i++) begin
            @(negedge clk_in);
            clear_err = 1'b0;
            if (i >= hi) div_clk = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_locked"},      32'(locked),      32'd0);
        check_eq({tag, "_err_period"},  32'(err_period),  32'd0);
        check_eq({tag, "_err_duty"},    32'(err_duty),    32'd0);
        check_eq({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
        check_eq({tag, "_period_q"},    32'(period_q),    32'd0);
        check_eq({tag, "_high_q"},      32'(high_q),      32'd0);
        check_eq({tag, "_rise_count"},  32'(rise_count),  32'd0);
    endtask

    // Monitor: on every sampled rise, pop the expected entry and compare
    initial begin : monitor
        logic prev;
        logic r;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk_in);
            r    = div_clk & ~prev;
            prev = div_clk;
            if (r) begin
                #1;
                check_eq("sb_entry_present", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("locked",      32'(locked),      32'(e.lk));
                    check_eq("err_period",  32'(err_period),  32'(e.errs[2]));
                    check_eq("err_duty",    32'(err_duty),    32'(e.errs[1]));
                    check_eq("err_timeout", 32'(err_timeout), 32'(e.errs[0]));
                    check_eq("rise_count",  32'(rise_count),  32'(e.rc));
                    if (e.meas) begin
                        check_eq("period_q", 32'(period_q), 32'(e.period));
                        check_eq("high_q",   32'(high_q),   32'(e.high));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus script
    initial begin : driver
        rst       = 1'b1;
        enable    = 1'b0;
        div_clk   = 1'b0;
        clear_err = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_all_zero("reset");
        rst    = 1'b0;
        enable = 1'b1;

        // Nominal acquire and lock: 1 acquire rise + 4 good periods
        pulse(7, 4, 0, 0, 0, 3'b000);
        pulse(7, 4, 0, 1, 0, 3'b000);
        pulse(7, 4, 0, 1, 0, 3'b000);
        pulse(7, 4, 0, 1, 0, 3'b000);
        pulse(7, 3, 0, 1, 1, 3'b000);
        // High time 3 is legal, high time 2 drops lock
        pulse(7, 2, 0, 1, 1, 3'b000);
        pulse(7, 4, 0, 1, 0, 3'b010);
        pulse(7, 4, 0, 1, 0, 3'b010);
        pulse(7, 4, 0, 1, 0, 3'b010);
        pulse(7, 4, 0, 1, 0, 3'b010);
        // Relock, then an 8-cycle period; clear_err coincides with that rise
        pulse(8, 4, 0, 1, 1, 3'b010);
        pulse(7, 4, 1, 1, 0, 3'b100);
        pulse(7, 4, 0, 1, 0, 3'b100);
        // Standalone clear during the low phase, one edge before the next rise
        clear_err = 1'b1;
        pulse(7, 4, 0, 1, 0, 3'b000);
        pulse(7, 4, 0, 1, 0, 3'b000);
        pulse(7, 4, 0, 1, 1, 3'b000);

        // Stuck low while locked: timeout exactly 14 edges after the last rise
        repeat (8) @(posedge clk_in);
        #1;
        check_eq("pre_timeout_err", 32'(err_timeout), 32'd0);
        check_eq("pre_timeout_locked", 32'(locked), 32'd1);
        @(posedge clk_in);
        #1;
        check_eq("timeout_err", 32'(err_timeout), 32'd1);
        check_eq("timeout_locked", 32'(locked), 32'd0);

        // Reacquire from ACQUIRE and relock
        pulse(7, 4, 0, 0, 0, 3'b001);
        pulse(7, 4, 0, 1, 0, 3'b001);
        pulse(7, 4, 0, 1, 0, 3'b001);
        pulse(7, 4, 0, 1, 0, 3'b001);
        pulse(7, 4, 0, 1, 1, 3'b001);

        // One-cycle reset while locked
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        check_all_zero("midlock_reset");
        @(negedge clk_in);
        rst    = 1'b0;
        rc_exp = 0;
        pulse(7, 4, 0, 0, 0, 3'b000);
        pulse(7, 4, 0, 1, 0, 3'b000);

        @(posedge clk_in);
        #2;
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
